// File: rtl/rk8e_data_break.sv
// RK8E data-break initiator: moves one sector between the disk word stream and core memory.
// Optional build macro RK8E_FIELD_CARRY_EN lets an address carry out of 7777 advance the field.
module rk8e_data_break #(
    parameter int SECTOR_WORDS = 256,
    parameter int HALF_WORDS   = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir_to_disk,
    input  logic        half,
    input  logic [14:0] start_addr,
    input  logic [11:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [11:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        data_break,
    output logic [14:0] dmaAddr,
    output logic [11:0] disk2mem,
    output logic        to_disk,
    input  logic [11:0] mem2disk,
    input  logic        db_done,
    output logic        busy,
    output logic        done,
    output logic        wrapped,
    output logic [14:0] cur_addr
);
    localparam int CW = $clog2(SECTOR_WORDS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GET  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_PUT  = 3'd4;
    localparam logic [2:0] S_ADV  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [14:0]   addr_q, addr_d;
    logic          wrapped_q, wrapped_d;
    logic [11:0]   d2m_q, d2m_d;
    logic [11:0]   tx_q, tx_d;
    logic [12:0]   inc;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        d2m_d     = d2m_q;
        tx_d      = tx_q;
        inc       = {1'b0, addr_q[11:0]} + 13'd1;
        case (state_q)
            S_IDLE: if (start) begin
                dir_d     = dir_to_disk;
                cnt_d     = half ? CW'(HALF_WORDS) : CW'(SECTOR_WORDS);
                addr_d    = start_addr;
                wrapped_d = 1'b0;
                state_d   = dir_to_disk ? S_REQ : S_GET;
            end
            S_GET: if (rx_valid) begin
                d2m_d   = rx_data;
                state_d = S_REQ;
            end
            S_REQ: if (db_done) state_d = dir_q ? S_CAP : S_ADV;
            S_CAP: begin
                tx_d    = mem2disk;
                state_d = S_PUT;
            end
            S_PUT: if (tx_ready) state_d = S_ADV;
            S_ADV: begin
                addr_d[11:0] = inc[11:0];
                if (inc[12]) begin
`ifdef RK8E_FIELD_CARRY_EN
                    addr_d[14:12] = addr_q[14:12] + 3'd1;
                    if (addr_q[14:12] == 3'd7) wrapped_d = 1'b1;
`else
                    wrapped_d = 1'b1;
`endif
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIN;
                else                 state_d = dir_q ? S_REQ : S_GET;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
            d2m_q     <= '0;
            tx_q      <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            d2m_q     <= d2m_d;
            tx_q      <= tx_d;
        end
    end

    // Handshake outputs decode straight from state, so they drop with the state change.
    assign rx_ready   = (state_q == S_GET);
    assign tx_valid   = (state_q == S_PUT);
    assign data_break = (state_q == S_REQ);
    assign to_disk    = (state_q == S_REQ) & dir_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done       = (state_q == S_FIN);
    assign dmaAddr    = addr_q;
    assign cur_addr   = addr_q;
    assign disk2mem   = d2m_q;
    assign tx_data    = tx_q;
    assign wrapped    = wrapped_q;
endmodule

// File: tb/tb_rk8e_data_break.sv
// Directed/randomized bench for rk8e_data_break against a sector-level address/data model.
module tb_rk8e_data_break;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, dir_to_disk = 1'b0, half = 1'b0;
    logic [14:0] start_addr = '0;
    logic [11:0] rx_data = '0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0, db_done = 1'b0;
    logic        rx_ready, tx_valid, data_break, to_disk, busy, done, wrapped;
    logic [11:0] tx_data, disk2mem, mem2disk;
    logic [14:0] dmaAddr, cur_addr;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    // Memory responder: each location holds the low 12 bits of its own address.
    assign mem2disk = dmaAddr[11:0];

    rk8e_data_break dut (
        .clk(clk), .reset(reset), .start(start), .dir_to_disk(dir_to_disk), .half(half),
        .start_addr(start_addr), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .data_break(data_break),
        .dmaAddr(dmaAddr), .disk2mem(disk2mem), .to_disk(to_disk), .mem2disk(mem2disk),
        .db_done(db_done), .busy(busy), .done(done), .wrapped(wrapped), .cur_addr(cur_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // i-th break address of a transfer starting at s
    function automatic logic [14:0] exp_addr(input logic [14:0] s, input int i);
`ifdef RK8E_FIELD_CARRY_EN
        return 15'((int'(s) + i) % 32768);
`else
        return {s[14:12], 12'((int'(s[11:0]) + i) % 4096)};
`endif
    endfunction

    function automatic logic exp_wrap(input logic [14:0] s, input int n);
`ifdef RK8E_FIELD_CARRY_EN
        return (int'(s) + n) >= 32768;
`else
        return (int'(s[11:0]) + n) >= 4096;
`endif
    endfunction

    task automatic do_start(input logic dir, input logic hf, input logic [14:0] a);
        start = 1'b1; dir_to_disk = dir; half = hf; start_addr = a;
        cyc();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic read_word(input logic [11:0] w, input logic [14:0] ea, input int dly,
                             input bit last, input bit spurious);
        if (spurious) begin
            db_done = 1'b1; start = 1'b1; dir_to_disk = 1'b1; half = 1'b1;
            start_addr = 15'($urandom);
            cyc();
            db_done = 1'b0; start = 1'b0;
            chk("spurious_still_get", rx_ready, 1);
            chk("spurious_no_break", data_break, 0);
        end
        chk("rx_ready", rx_ready, 1);
        rx_data = w; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        chk("rd_break", data_break, 1);
        chk("rd_addr", dmaAddr, ea);
        chk("rd_data", disk2mem, w);
        chk("rd_to_disk", to_disk, 0);
        chk("rd_one_word", rx_ready, 0);
        for (int k = 0; k < dly; k++) begin
            cyc();
            chk("rd_hold_break", data_break, 1);
            chk("rd_hold_addr", dmaAddr, ea);
            chk("rd_hold_data", disk2mem, w);
        end
        db_done = 1'b1;
        cyc();
        db_done = 1'b0;
        chk("rd_break_drop", data_break, 0);
        cyc();
        if (last) begin
            chk("rd_done", done, 1);
            chk("rd_busy_fin", busy, 0);
        end else begin
            chk("rd_no_done", done, 0);
        end
    endtask

    task automatic write_word(input logic [14:0] ea, input int dly, input int stall,
                              input bit last, input bit extra_start);
        chk("wr_break", data_break, 1);
        chk("wr_addr", dmaAddr, ea);
        chk("wr_to_disk", to_disk, 1);
        for (int k = 0; k < dly; k++) begin
            cyc();
            chk("wr_hold_break", data_break, 1);
        end
        if (extra_start) begin
            start = 1'b1; dir_to_disk = 1'b0; half = 1'b0; start_addr = 15'o12345;
            cyc();
            start = 1'b0;
            chk("extra_start_break", data_break, 1);
            chk("extra_start_addr", dmaAddr, ea);
            chk("extra_start_dir", to_disk, 1);
        end
        db_done = 1'b1;
        cyc();
        db_done = 1'b0;
        chk("wr_break_drop", data_break, 0);
        cyc();
        chk("wr_tx_valid", tx_valid, 1);
        chk("wr_tx_data", tx_data, ea[11:0]);
        for (int k = 0; k < stall; k++) begin
            cyc();
            chk("stall_tx_valid", tx_valid, 1);
            chk("stall_tx_data", tx_data, ea[11:0]);
            chk("stall_no_break", data_break, 0);
        end
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        chk("wr_tx_drop", tx_valid, 0);
        cyc();
        if (last) begin
            chk("wr_done", done, 1);
            chk("wr_busy_fin", busy, 0);
        end else begin
            chk("wr_no_done", done, 0);
        end
    endtask

    task automatic check_end(input logic [14:0] s, input int n);
        chk("end_cur_addr", cur_addr, exp_addr(s, n));
        chk("end_wrapped", wrapped, exp_wrap(s, n));
        cyc();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [14:0] s;
        repeat (2) cyc();
        chk("rst_data_break", data_break, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_dmaAddr", dmaAddr, 0);
        chk("rst_tx_data", tx_data, 0);
        reset = 1'b0;
        cyc();

        // Full-block read from 1 0200, words 0000..0377.
        s = 15'o10200;
        do_start(1'b0, 1'b0, s);
        for (int i = 0; i < 256; i++)
            read_word(12'(i), exp_addr(s, i), 2, i == 255, 0);
        check_end(s, 256);

        // Half-block write from 0 4000, stall on word 3, stray start on word 10.
        s = 15'o04000;
        do_start(1'b1, 1'b1, s);
        for (int i = 0; i < 128; i++)
            write_word(exp_addr(s, i), int'($urandom_range(0, 2)), (i == 3) ? 5 : 0,
                       i == 127, i == 10);
        check_end(s, 128);

        // Wrap from 2 7776 (half block), plus a slow grant and a spurious db_done.
        s = 15'o27776;
        do_start(1'b0, 1'b1, s);
        for (int i = 0; i < 128; i++)
            read_word(12'($urandom), exp_addr(s, i), (i == 1) ? 20 : int'($urandom_range(0, 3)),
                      i == 127, i == 2);
        check_end(s, 128);

        // Reset while a break is pending.
        s = 15'(($urandom & 15'o77777));
        do_start(1'b0, 1'b1, s);
        read_word(12'($urandom), exp_addr(s, 0), 1, 0, 0);
        rx_data = 12'o5252; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        chk("pre_rst_break", data_break, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_break", data_break, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_dmaAddr", dmaAddr, 0);
        chk("async_rst_disk2mem", disk2mem, 0);
        chk("async_rst_wrapped", wrapped, 0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("no_done_after_rst", done, 0);
            chk("idle_after_rst", busy, 0);
        end

        // Clean transfer after reset.
        s = 15'o31234;
        do_start(1'b0, 1'b1, s);
        for (int i = 0; i < 128; i++)
            read_word(12'($urandom), exp_addr(s, i), int'($urandom_range(0, 2)), i == 127, 0);
        check_end(s, 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
